// File: rtl/ula_pkg.sv
// Shared opcode constants and FSM state type for the multi-cycle ALU.
package ula_pkg;

    localparam logic [2:0] ULA_PASSA = 3'b000;
    localparam logic [2:0] ULA_SOMA  = 3'b001;
    localparam logic [2:0] ULA_SUB   = 3'b010;
    localparam logic [2:0] ULA_MUL   = 3'b101;
    localparam logic [2:0] ULA_DIV   = 3'b110;

    typedef enum logic [1:0] {
        OCIOSO,
        CALCULA,
        FIM
    } estado_t;

endpackage

// File: rtl/ula_divisor.sv
// Iterative restoring signed divider: LARGURA cycles, quotient truncated toward zero.
module ula_divisor #(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
    input  logic [LARGURA-1:0] dividendo,
    input  logic [LARGURA-1:0] divisor,
    output logic               pronto,
    output logic [LARGURA-1:0] quociente
);

    localparam int CW = $clog2(LARGURA);

    logic               ocupado;
    logic [CW-1:0]      cnt;
    logic [LARGURA-1:0] resto, quo, dmag;
    logic               neg;
    logic [LARGURA:0]   desloc, dif;
    logic [LARGURA-1:0] resto_prox, quo_prox;

    always_comb begin
        desloc = {resto, quo[LARGURA-1]};
        dif    = desloc - {1'b0, dmag};
        if (dif[LARGURA]) begin
            resto_prox = desloc[LARGURA-1:0];
            quo_prox   = {quo[LARGURA-2:0], 1'b0};
        end else begin
            resto_prox = dif[LARGURA-1:0];
            quo_prox   = {quo[LARGURA-2:0], 1'b1};
        end
    end

    // The last iteration is consumed combinationally so the result is ready on the done cycle.
    assign pronto    = ocupado && (cnt == '0);
    assign quociente = neg ? -quo_prox : quo_prox;

    always_ff @(posedge clock) begin
        if (reset) begin
            ocupado <= 1'b0;
            cnt     <= '0;
            resto   <= '0;
            quo     <= '0;
            dmag    <= '0;
            neg     <= 1'b0;
        end else if (inicio) begin
            ocupado <= 1'b1;
            cnt     <= CW'(LARGURA - 1);
            resto   <= '0;
            quo     <= dividendo[LARGURA-1] ? -dividendo : dividendo;
            dmag    <= divisor[LARGURA-1] ? -divisor : divisor;
            neg     <= dividendo[LARGURA-1] ^ divisor[LARGURA-1];
        end else if (ocupado) begin
            resto <= resto_prox;
            quo   <= quo_prox;
            cnt   <= cnt - CW'(1);
            if (cnt == '0)
                ocupado <= 1'b0;
        end
    end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle signed ALU (pass/add/sub/shift-add mul/restoring div).
// Divider compiled in only when ULA_DIVISAO_EN is defined.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
    input  logic [2:0]         selecao,
    input  logic [LARGURA-1:0] var_X,
    input  logic [LARGURA-1:0] var_Y,
    output logic [LARGURA-1:0] resultado,
    output logic               flag_N,
    output logic               flag_Z,
    output logic               flag_DZ,
    output logic               ocupado,
    output logic               pronto
);

    localparam int CW = $clog2(LARGURA);

    estado_t            estado, prox_estado;
    logic [2:0]         op_reg;
    logic [LARGURA-1:0] x_reg, y_reg;
    logic [CW-1:0]      cnt;
    logic [LARGURA-1:0] mul_acc, mul_a, mul_b, mul_acc_prox;
    logic [LARGURA-1:0] res_calc;
    logic               aceita, fim_calc;

    assign aceita  = (estado == OCIOSO) && inicio;
    assign ocupado = (estado != OCIOSO);
    assign pronto  = (estado == FIM);

`ifdef ULA_DIVISAO_EN
    logic               dz_reg;
    logic               div_inicio, div_pronto;
    logic [LARGURA-1:0] div_q;

    assign div_inicio = aceita && (selecao == ULA_DIV) && (var_Y != '0);

    ula_divisor #(.LARGURA(LARGURA)) u_divisor (
        .clock     (clock),
        .reset     (reset),
        .inicio    (div_inicio),
        .dividendo (var_X),
        .divisor   (var_Y),
        .pronto    (div_pronto),
        .quociente (div_q)
    );
`else
    assign flag_DZ = 1'b0;
`endif

    assign mul_acc_prox = mul_acc + (mul_b[0] ? mul_a : '0);

    always_comb begin
        prox_estado = estado;
        fim_calc    = 1'b0;
        case (estado)
            OCIOSO: if (inicio) prox_estado = CALCULA;
            CALCULA: begin
                if (op_reg == ULA_MUL)
                    fim_calc = (cnt == '0);
`ifdef ULA_DIVISAO_EN
                else if ((op_reg == ULA_DIV) && !dz_reg)
                    fim_calc = div_pronto;
`endif
                else
                    fim_calc = 1'b1;
                if (fim_calc)
                    prox_estado = FIM;
            end
            FIM:     prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    always_comb begin
        res_calc = '0;
        case (op_reg)
            ULA_PASSA: res_calc = x_reg;
            ULA_SOMA:  res_calc = x_reg + y_reg;
            ULA_SUB:   res_calc = x_reg - y_reg;
            ULA_MUL:   res_calc = mul_acc_prox;
`ifdef ULA_DIVISAO_EN
            ULA_DIV:   res_calc = dz_reg ? '0 : div_q;
`endif
            default:   res_calc = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= OCIOSO;
            op_reg    <= ULA_PASSA;
            x_reg     <= '0;
            y_reg     <= '0;
            cnt       <= '0;
            mul_acc   <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            resultado <= '0;
            flag_N    <= 1'b0;
            flag_Z    <= 1'b1;
`ifdef ULA_DIVISAO_EN
            dz_reg    <= 1'b0;
            flag_DZ   <= 1'b0;
`endif
        end else begin
            estado <= prox_estado;
            if (aceita) begin
                op_reg  <= selecao;
                x_reg   <= var_X;
                y_reg   <= var_Y;
                cnt     <= CW'(LARGURA - 1);
                mul_acc <= '0;
                mul_a   <= var_X;
                mul_b   <= var_Y;
`ifdef ULA_DIVISAO_EN
                dz_reg  <= (selecao == ULA_DIV) && (var_Y == '0);
`endif
            end else if (estado == CALCULA) begin
                mul_acc <= mul_acc_prox;
                mul_a   <= mul_a << 1;
                mul_b   <= mul_b >> 1;
                cnt     <= cnt - CW'(1);
            end
            if (fim_calc) begin
                resultado <= res_calc;
                flag_N    <= res_calc[LARGURA-1];
                flag_Z    <= (res_calc == '0);
`ifdef ULA_DIVISAO_EN
                flag_DZ   <= (op_reg == ULA_DIV) && dz_reg;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Randomized self-checking bench: LARGURA=32 and LARGURA=8 instances against an arithmetic model.
module tb_ula_multiciclo;

    logic        clock, reset, inicio;
    logic [2:0]  selecao;
    logic [31:0] var_X_a, var_Y_a, resultado_a;
    logic [7:0]  var_X_b, var_Y_b, resultado_b;
    logic        flag_N_a, flag_Z_a, flag_DZ_a, ocupado_a, pronto_a;
    logic        flag_N_b, flag_Z_b, flag_DZ_b, ocupado_b, pronto_b;

    int n_comp   = 0;
    int n_falhas = 0;

    ula_multiciclo dut_a (
        .clock(clock), .reset(reset), .inicio(inicio), .selecao(selecao),
        .var_X(var_X_a), .var_Y(var_Y_a), .resultado(resultado_a),
        .flag_N(flag_N_a), .flag_Z(flag_Z_a), .flag_DZ(flag_DZ_a),
        .ocupado(ocupado_a), .pronto(pronto_a)
    );

    ula_multiciclo #(.LARGURA(8)) dut_b (
        .clock(clock), .reset(reset), .inicio(inicio), .selecao(selecao),
        .var_X(var_X_b), .var_Y(var_Y_b), .resultado(resultado_b),
        .flag_N(flag_N_b), .flag_Z(flag_Z_b), .flag_DZ(flag_DZ_b),
        .ocupado(ocupado_b), .pronto(pronto_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_comp++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Result from signed integer arithmetic, truncated to w bits; also flags and latency.
    function automatic logic [63:0] modelo(input logic [2:0] op, input longint sx, input longint sy,
                                           input int w, output logic dz, output int lat);
        longint r;
        dz  = 1'b0;
        lat = 2;
        case (op)
            3'b000: r = sx;
            3'b001: r = sx + sy;
            3'b010: r = sx - sy;
            3'b101: begin r = sx * sy; lat = w + 1; end
            3'b110: begin
`ifdef ULA_DIVISAO_EN
                if (sy == 0) begin r = 0; dz = 1'b1; end
                else begin r = sx / sy; lat = w + 1; end
`else
                r = 0;
`endif
            end
            default: r = 0;
        endcase
        return 64'(r) & ((64'd1 << w) - 64'd1);
    endfunction

    task automatic verifica_reset();
        verifica("rst_res32", resultado_a, 0);
        verifica("rst_n32",   flag_N_a, 0);
        verifica("rst_z32",   flag_Z_a, 1);
        verifica("rst_dz32",  flag_DZ_a, 0);
        verifica("rst_ocup32", ocupado_a, 0);
        verifica("rst_pronto32", pronto_a, 0);
        verifica("rst_res8",  resultado_b, 0);
        verifica("rst_z8",    flag_Z_b, 1);
        verifica("rst_ocup8", ocupado_b, 0);
    endtask

    task automatic espera_ocioso();
        int c;
        for (c = 0; c < 100 && (ocupado_a || ocupado_b); c++) begin
            @(posedge clock); #1;
        end
        verifica("ocioso_timeout", {63'd0, ocupado_a | ocupado_b}, 0);
    endtask

    task automatic executa(input logic [2:0] op, input logic [31:0] xa, input logic [31:0] ya,
                           input logic [7:0] xb, input logic [7:0] yb);
        logic [63:0] ea, eb;
        logic        dza, dzb;
        int          la, lb, lat_a, lat_b, np_a, np_b;
        logic [31:0] ra;
        logic [7:0]  rb;
        logic        na, za, da, nb, zb, db;
        ea = modelo(op, longint'(signed'(xa)), longint'(signed'(ya)), 32, dza, la);
        eb = modelo(op, longint'(signed'(xb)), longint'(signed'(yb)), 8, dzb, lb);
        lat_a = 0; lat_b = 0; np_a = 0; np_b = 0;
        ra = '0; rb = '0; na = 0; za = 0; da = 0; nb = 0; zb = 0; db = 0;
        inicio = 1'b1; selecao = op;
        var_X_a = xa; var_Y_a = ya; var_X_b = xb; var_Y_b = yb;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clock); #1;
            if (c == 1) begin
                inicio  = 1'b0;
                selecao = 3'($urandom);
                var_X_a = $urandom; var_Y_a = $urandom;
                var_X_b = 8'($urandom); var_Y_b = 8'($urandom);
                verifica("ocup32", ocupado_a, 1);
                verifica("ocup8", ocupado_b, 1);
            end
            if (pronto_a) begin
                np_a++;
                if (lat_a == 0) begin
                    lat_a = c; ra = resultado_a; na = flag_N_a; za = flag_Z_a; da = flag_DZ_a;
                end
            end
            if (pronto_b) begin
                np_b++;
                if (lat_b == 0) begin
                    lat_b = c; rb = resultado_b; nb = flag_N_b; zb = flag_Z_b; db = flag_DZ_b;
                end
            end
            if (lat_a != 0 && lat_b != 0 && c > lat_a && c > lat_b) break;
        end
        verifica("lat32", lat_a, la);
        verifica("res32", ra, ea);
        verifica("n32", na, ea[31]);
        verifica("z32", za, ea == 0);
        verifica("dz32", da, dza);
        verifica("pulsos32", np_a, 1);
        verifica("fim_ocup32", ocupado_a, 0);
        verifica("lat8", lat_b, lb);
        verifica("res8", rb, eb);
        verifica("n8", nb, eb[7]);
        verifica("z8", zb, eb == 0);
        verifica("dz8", db, dzb);
        verifica("pulsos8", np_b, 1);
        verifica("fim_ocup8", ocupado_b, 0);
    endtask

    task automatic teste_inicio_mantido();
        int np;
        np = 0;
        inicio = 1'b1; selecao = 3'b101;
        var_X_a = 32'hFFFFFFFD; var_Y_a = 32'd5; var_X_b = 8'hFD; var_Y_b = 8'd5;
        for (int c = 1; c <= 33; c++) begin
            @(posedge clock); #1;
            if (c == 1) begin
                var_X_a = $urandom; var_Y_a = $urandom;
            end
            if (pronto_a) begin
                np++;
                verifica("mant_lat", c, 33);
                verifica("mant_res", resultado_a, 32'hFFFFFFF1);
                verifica("mant_n", flag_N_a, 1);
            end
        end
        verifica("mant_pulsos", np, 1);
        @(posedge clock); #1;
        verifica("mant_ocioso", ocupado_a, 0);
        @(posedge clock); #1;
        verifica("mant_reinicio", ocupado_a, 1);
        inicio = 1'b0;
        espera_ocioso();
    endtask

    task automatic teste_reset();
        int np;
        executa(3'b000, 32'h00001234, 32'd0, 8'h12, 8'd0);
`ifdef ULA_DIVISAO_EN
        selecao = 3'b110;
`else
        selecao = 3'b101;
`endif
        inicio = 1'b1;
        var_X_a = 32'hFFFFFC18; var_Y_a = 32'd7; var_X_b = 8'h9C; var_Y_b = 8'd7;
        @(posedge clock); #1;
        inicio = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        verifica("meio_ocup32", ocupado_a, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        verifica_reset();
        np = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clock); #1;
            if (pronto_a || pronto_b) np++;
        end
        verifica("reset_sem_pronto", np, 0);
        verifica("reset_res_mantido", resultado_a, 0);
        reset = 1'b1; inicio = 1'b1; selecao = 3'b000; var_X_a = 32'd5;
        @(posedge clock); #1;
        verifica("prio_ocup32", ocupado_a, 0);
        reset = 1'b0; inicio = 1'b0;
        @(posedge clock); #1;
        verifica("prio_ocioso32", ocupado_a, 0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] xa, ya;
        logic [7:0]  xb, yb;
        reset = 1'b1; inicio = 1'b0; selecao = '0;
        var_X_a = '0; var_Y_a = '0; var_X_b = '0; var_Y_b = '0;
        repeat (2) @(posedge clock);
        #1;
        verifica_reset();
        reset = 1'b0;

        executa(3'b001, 32'd7, 32'hFFFFFFF9, 8'h07, 8'hF9);
        executa(3'b101, 32'hFFFFFFFD, 32'd5, 8'hFD, 8'h05);
        executa(3'b110, 32'hFFFFFFF9, 32'd2, 8'hF9, 8'h02);
        executa(3'b110, 32'd100, 32'd0, 8'd100, 8'd0);
        executa(3'b110, 32'h80000000, 32'hFFFFFFFF, 8'h80, 8'hFF);
        executa(3'b010, 32'h80000000, 32'd1, 8'h80, 8'h01);
        executa(3'b011, 32'd5, 32'd9, 8'd5, 8'd9);
        executa(3'b000, 32'h80000001, 32'd0, 8'h81, 8'd0);

        teste_inicio_mantido();

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            xa = $urandom; ya = $urandom;
            xb = 8'($urandom); yb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin ya = '0; yb = '0; end
            if ($urandom_range(0, 3) == 0) begin ya = ya >> $urandom_range(8, 30); end
            executa(op, xa, ya, xb, yb);
        end

        teste_reset();
        executa(3'b001, 32'd40, 32'd2, 8'd40, 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_falhas);
        $finish;
    end

endmodule

// File: doc/ula_multiciclo.md
ULA_MULTICICLO -- requirements
Module: ula_multiciclo

Interface
REQ-001 SHALL have parameter LARGURA, default 32, operand/result width in bits (legal range 8..64).
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port inicio  input  1  start request; sampled only while ocupado=0.
REQ-005 SHALL have port selecao  input  3  opcode: 000 pass X, 001 X+Y, 010 X-Y, 101 X*Y, 110 X/Y, others reserved.
REQ-006 SHALL have port var_X  input  LARGURA  signed operand X.
REQ-007 SHALL have port var_Y  input  LARGURA  signed operand Y.
REQ-008 SHALL have port resultado  output  LARGURA  signed result, registered.
REQ-009 SHALL have port flag_N  output  1  resultado[LARGURA-1] of the latest completed operation.
REQ-010 SHALL have port flag_Z  output  1  resultado equals zero for the latest completed operation.
REQ-011 SHALL have port flag_DZ  output  1  latest operation was a division by zero.
REQ-012 SHALL have port ocupado  output  1  operation in progress; inicio ignored.
REQ-013 SHALL have port pronto  output  1  one-cycle pulse; resultado and flags valid and updated this cycle.

Function
REQ-014 SHALL implement FSM states OCIOSO, CALCULA, FIM; OCIOSO->CALCULA on inicio=1; CALCULA->FIM when the iteration counter expires; FIM->OCIOSO unconditionally.
REQ-015 SHALL capture selecao, var_X, var_Y in the cycle inicio is accepted; later input changes SHALL NOT affect the running operation.
REQ-016 SHALL assert ocupado in CALCULA and FIM, and pronto only in FIM.
REQ-017 SHALL complete opcodes 000, 001, 010 and reserved opcodes in one CALCULA cycle: pronto 2 cycles after the accepting edge.
REQ-018 SHALL compute 001/010 modulo 2^LARGURA (wrap, no overflow flag).
REQ-019 SHALL compute 101 with an iterative signed shift-add multiplier, LARGURA CALCULA cycles, result = low LARGURA bits of the signed product.
REQ-020 SHALL compute 110 with an iterative restoring divider on magnitudes, LARGURA CALCULA cycles, quotient truncated toward zero, sign = sign(X) xor sign(Y).
REQ-021 SHALL, for 110 with var_Y=0, skip iteration: one CALCULA cycle, resultado=0, flag_DZ=1, flag_Z=1.
REQ-022 SHALL, for 110 with X = most-negative and Y = -1, return most-negative (wrap), flag_DZ=0.
REQ-023 SHALL return resultado=0, flag_Z=1 for reserved opcodes.
REQ-024 SHALL update resultado and flags only on entry to FIM, holding them until the next completed operation.
REQ-025 SHALL ignore inicio while ocupado=1 (no queueing); inicio in the FIM cycle is ignored, accepted next cycle in OCIOSO.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, force OCIOSO and resultado=0, flag_N=0, flag_Z=1, flag_DZ=0, ocupado=0, pronto=0.
REQ-027 SHALL abort an operation in progress on reset, producing no pronto pulse for it.
REQ-028 SHALL give reset priority over inicio in the same cycle.

Configuration
REQ-029 SHALL use macro ULA_DIVISAO_EN: defined -> divider of REQ-020..022 compiled in; undefined -> no divider hardware, opcode 110 treated as reserved (REQ-023), flag_DZ tied to 0.

Structure
REQ-030 SHALL place opcode constants (ULA_PASSA, ULA_SOMA, ULA_SUB, ULA_MUL, ULA_DIV) and the FSM state type in shared package ula_pkg.
REQ-031 SHALL implement the division datapath as sub-module ula_divisor (LARGURA-parametrised, start/done handshake), instantiated only under ULA_DIVISAO_EN.

Verification
REQ-032 SHALL cover: LARGURA=32, 001, X=7, Y=-7 -> pronto 2 cycles after inicio, resultado=0, flag_Z=1, flag_N=0.
REQ-033 SHALL cover: 101, X=-3, Y=5 -> pronto after LARGURA+1 cycles, resultado=-15, flag_N=1; inputs changed during CALCULA do not alter result.
REQ-034 SHALL cover: 110, X=-7, Y=2 -> resultado=-3; X=100, Y=0 -> resultado=0, flag_DZ=1 after 2 cycles; X=0x80000000, Y=-1 -> 0x80000000.
REQ-035 SHALL cover: inicio held high during a 101 operation -> exactly one pronto, next operation starts only from OCIOSO.
REQ-036 SHALL cover: reset asserted mid-division -> no pronto, outputs at reset values next cycle; rerun with LARGURA=8 and ULA_DIVISAO_EN undefined -> 110 returns 0, flag_Z=1, flag_DZ=0.
